// File: rtl/slave_out_port_pkg.sv
// Shared slave-port bus definitions: transmit FSM state codes, default word width, read opcode.
// Latency: none (types, constants and a width helper only).
// Backpressure: none.
package slave_out_port_pkg;

  // Default read-word width for the slave port.
  localparam int DEFAULT_DATA_LEN = 8;

  // Read-instruction opcode; the master side decodes the same value.
  localparam logic [1:0] READ_INSTR = 2'b11;

  // Transmit FSM states. The numeric values are visible on the temp_state debug port.
  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    WAIT_HANDSHAKE = 2'd1,
    SEND_DATA      = 2'd2
  } tx_state_t;

  // Bit counter width. The extra bit keeps DATA_LEN itself representable, so the
  // counter never wraps before the last bit index.
  function automatic int count_width(input int len);
    return $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/slave_out_port.sv
// Slave-port transmitter: serialises one read word LSB first to the master, one bit per clock.
// Latency: slave_valid one cycle after tx_start; bit k sampled k+1 edges after the handshake request; tx_done DATA_LEN+1 cycles after start.
// Backpressure: master_ready gates only the first bit (the handshake); the remaining bits stream unconditionally, and tx_start is dropped while busy.
module slave_out_port
  import slave_out_port_pkg::*;
#(
  parameter int DATA_LEN = DEFAULT_DATA_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                tx_start,
  output logic                tx_busy,
  output logic                tx_done,
  output logic                tx_data,
  output logic                slave_valid,
  input  logic                master_ready,
  output logic [1:0]          temp_state
);

  localparam int CNT_W = count_width(DATA_LEN);

  // Index of the bit presented in the final SEND_DATA cycle.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_LEN - 1);

  tx_state_t           state;
  logic [CNT_W-1:0]    count;
  logic [DATA_LEN-1:0] shift_reg;

  // The bit under the master's sample point is always the shift register's LSB.
  assign tx_data    = shift_reg[0];
  assign tx_busy    = (state != IDLE);
  assign temp_state = state;

  // Transmit FSM: capture on start, wait for the master's grant on bit 0, then stream the rest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      shift_reg   <= '0;
      slave_valid <= 1'b0;
      tx_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // tx_done lasts a single cycle; a new start in that same cycle is still taken.
          tx_done     <= 1'b0;
          slave_valid <= 1'b0;
          if (tx_start) begin
            shift_reg   <= data_in;
            count       <= '0;
            slave_valid <= 1'b1;
            state       <= WAIT_HANDSHAKE;
          end
        end

        WAIT_HANDSHAKE: begin
          tx_done <= 1'b0;
          // Bit 0 is held on the line until the master grants; it samples it on this edge.
          if (master_ready) begin
            shift_reg   <= shift_reg >> 1;
            count       <= CNT_W'(1);
            slave_valid <= 1'b0;
            if (DATA_LEN == 1) begin
              count   <= '0;
              tx_done <= 1'b1;
              state   <= IDLE;
            end else begin
              state <= SEND_DATA;
            end
          end
        end

        SEND_DATA: begin
          shift_reg <= shift_reg >> 1;
          if (count == LAST_IDX) begin
            // The last bit is sampled on this edge; the word is complete.
            count   <= '0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          count       <= '0;
          slave_valid <= 1'b0;
          tx_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/slave_out_port.md
Name: slave_out_port

Overview:
Transmit half of the slave port. It serialises one DATA_LEN-bit read word back to the master's receive port, LSB first, one bit per clock. It uses the slave_valid/master_ready handshake. It sits inside the slave port, between the slave's read-data source (memory or register file) and the bus return line.

Parameters:
DATA_LEN, 8, width of the read word in bits; legal range ≥1.

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_LEN  parallel read word from the slave; captured only on an accepted tx_start
tx_start  input  1  request to send data_in; accepted only in IDLE
tx_busy  output  1  high whenever state ≠ IDLE
tx_done  output  1  one-cycle pulse after the last bit has been sampled by the master
tx_data  output  1  serial bit line to the master (its rx_data)
slave_valid  output  1  handshake request to the master
master_ready  input  1  handshake grant from the master
temp_state  output  2  current state, for debug only

Behaviour:
- Reset (async, active-high) forces these values; a reset mid-transfer abandons the word with no tx_done:
  - state=IDLE, count=0, shift register=0
  - tx_data=0, slave_valid=0, tx_done=0, tx_busy=0
- All outputs are registered or driven directly from registers; there are no combinational paths from inputs to outputs.
- tx_data always equals shift_reg[0].
- IDLE:
  - slave_valid=0; tx_done is cleared on the first edge after it was set.
  - tx_start=1 at an edge: load shift_reg←data_in, count←0, slave_valid←1, go to WAIT_HANDSHAKE.
  - tx_start is honoured in the same cycle that tx_done is high.
- WAIT_HANDSHAKE:
  - Hold slave_valid=1 and tx_data=bit0 indefinitely until an edge with master_ready=1.
  - At that edge the master samples bit0. Shift right by one, count←1, slave_valid←0.
  - If DATA_LEN>1, go to SEND_DATA.
  - If DATA_LEN=1, go to IDLE with tx_done←1.
  - master_ready is not sampled anywhere except in WAIT_HANDSHAKE.
  - tx_start is ignored while busy; data_in changes after capture have no effect.
- SEND_DATA:
  - tx_data presents bit[count]; the master samples it on every edge without further handshake.
  - count<DATA_LEN-1: shift, count←count+1, stay.
  - count==DATA_LEN-1 (last bit sampled at this edge): count←0, go to IDLE, tx_done←1.
- Latency, with tx_start at edge E0 and master_ready already 1:
  - slave_valid is high after E0.
  - bit k is sampled at edge E(k+1).
  - tx_done is high for exactly one cycle after E(DATA_LEN).
  - Total DATA_LEN+1 cycles from start to done.
- If the handshake waits N extra cycles, every later event shifts by N.
- Bit order is LSB first, matching the master receive port, which writes data[count] starting at count 0.
- The system controller raises tx_start only once the master has issued a read and is in its wait-for-handshake state; this block does not police that.
- count width is $clog2(DATA_LEN)+1 bits, so count never wraps below DATA_LEN.

Decomposition:
- Shared bus package holds:
  - state encodings IDLE=0, WAIT_HANDSHAKE=1, SEND_DATA=2;
  - the DATA_LEN default;
  - read-instruction code 2'b11 (shared with the master side).
- No sub-module; a single flat FSM plus a shift register is the natural form.

Test Plan:
1. Reset, then tx_start with data_in=8'hA5 and master_ready held 1:
   - slave_valid=1 for 1 cycle;
   - tx_data sampled at E1..E8 = 1,0,1,0,0,1,0,1;
   - tx_done=1 only in the cycle after E8; tx_busy=0 after that.
2. tx_start with data_in=8'h3C and master_ready=0 for 5 cycles, then 1:
   - slave_valid and tx_data=0 stay stable for the 5 cycles;
   - the serial stream 0,0,1,1,1,1,0,0 begins at the edge where master_ready rises.
3. tx_start pulsed again and data_in changed to 8'hFF mid-transfer of 8'h81:
   - the stream stays 1,0,0,0,0,0,0,1 with exactly one tx_done;
   - the second tx_start is dropped.
4. Async reset asserted while count=4 of an 8'hF0 transfer:
   - immediately state=IDLE, slave_valid=0, tx_data=0;
   - no tx_done pulse; a subsequent tx_start with 8'h0F sends correctly.
5. Back-to-back words: tx_start asserted in the tx_done cycle of 8'h55, next word 8'hAA:
   - second slave_valid rises the following cycle;
   - the master model receives 8'h55 then 8'hAA.
6. DATA_LEN=1, data_in=1'b1:
   - tx_data=1 while waiting;
   - the handshake edge gives tx_done the next cycle and state returns to IDLE.
